md5_dispatch_scheduler: RTL and testbench

Job-level scheduler that shares a bank of up to 32 MD5 cracking units across a contiguous range of candidate indices. It accepts a job (base index, count) from the host-side control logic and flushes every unit. It then issues one start pulse per cycle, round-robin, to idle units, each start carrying the next candidate index. When all candidates have been issued and all issued units report done, it signals completion. It sits between the Avalon control slave and the per-unit `md5_start`/`md5_reset`/`md5_done` vectors.

---
 rtl/md5_dispatch_scheduler.sv | 175 +++++++++++++++++
 tb/tb_md5_dispatch_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_dispatch_scheduler.sv
// Round-robin job scheduler for a bank of MD5 cracking units: flushes the bank,
// issues one candidate index per cycle to idle units and reports completion.
module md5_dispatch_scheduler #(
  parameter int unsigned N_UNITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_base,
  input  logic [31:0] job_count,
  input  logic        abort,
  output logic [31:0] md5_start,
  output logic [31:0] md5_reset,
  input  logic [31:0] md5_done,
  output logic [31:0] cand_index,
  output logic [31:0] busy_mask,
  output logic [31:0] issued,
  output logic        job_done,
  output logic        job_aborted
);

  localparam logic [31:0] UNIT_MASK = 32'((64'd1 << N_UNITS) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_DISPATCH,
    S_DRAIN,
    S_ABORT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] count_q, count_d;
  logic [31:0] start_q, start_d;
  logic [31:0] mreset_q, mreset_d;
  logic [31:0] cand_q, cand_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] issued_q, issued_d;
  logic [4:0]  rr_q, rr_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;

  logic [31:0] done_seen;
  logic        pick_found;
  logic [4:0]  pick_idx;
  logic [4:0]  probe;
  logic        try_issue;

  // A done level on a unit being started this cycle is stale from its last run.
  assign done_seen = md5_done & busy_q & ~start_q & UNIT_MASK;

  always_comb begin : rr_pick
    pick_found = 1'b0;
    pick_idx   = '0;
    probe      = '0;
    for (int unsigned k = 0; k < N_UNITS; k++) begin
      probe = 5'((32'(rr_q) + k) % N_UNITS);
      if (!pick_found && !busy_q[probe]) begin
        pick_found = 1'b1;
        pick_idx   = probe;
      end
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    start_d   = '0;
    mreset_d  = '0;
    cand_d    = cand_q;
    busy_d    = busy_q & ~done_seen;
    issued_d  = issued_q;
    rr_d      = rr_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    try_issue = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          state_d  = S_FLUSH;
          base_d   = job_base;
          count_d  = job_count;
          issued_d = '0;
          busy_d   = '0;
          mreset_d = UNIT_MASK;
        end
      end
      S_FLUSH, S_DISPATCH: begin
        if (abort) begin
          state_d  = S_ABORT;
          mreset_d = UNIT_MASK;
          busy_d   = '0;
        end else if (state_q == S_FLUSH && count_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          state_d   = S_DISPATCH;
          try_issue = 1'b1;
        end
      end
      // DRAIN and ABORT linger one extra cycle so the pulse precedes job_ready.
      S_DRAIN: begin
        if (done_q) begin
          state_d = S_IDLE;
        end else if (abort) begin
          state_d  = S_ABORT;
          mreset_d = UNIT_MASK;
          busy_d   = '0;
        end else if (busy_q == '0) begin
          done_d = 1'b1;
        end
      end
      S_ABORT: begin
        if (aborted_q) begin
          state_d = S_IDLE;
        end else begin
          aborted_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (try_issue && pick_found) begin
      start_d  = 32'd1 << pick_idx;
      cand_d   = base_q + issued_q;
      busy_d   = busy_d | (32'd1 << pick_idx);
      issued_d = issued_q + 32'd1;
      rr_d     = (pick_idx == 5'(N_UNITS - 1)) ? '0 : pick_idx + 5'd1;
      if (issued_d == count_q) begin
        state_d = S_DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      start_q   <= '0;
      mreset_q  <= '0;
      cand_q    <= '0;
      busy_q    <= '0;
      issued_q  <= '0;
      rr_q      <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      start_q   <= start_d;
      mreset_q  <= mreset_d;
      cand_q    <= cand_d;
      busy_q    <= busy_d;
      issued_q  <= issued_d;
      rr_q      <= rr_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign job_ready   = (state_q == S_IDLE);
  assign md5_start   = start_q;
  assign md5_reset   = mreset_q;
  assign cand_index  = cand_q;
  assign busy_mask   = busy_q;
  assign issued      = issued_q;
  assign job_done    = done_q;
  assign job_aborted = aborted_q;

endmodule

// File: tb/tb_md5_dispatch_scheduler.sv
// Scoreboard bench for md5_dispatch_scheduler: driver queues expected candidate
// indices per job; a negedge monitor models the unit bank and checks every output.
module tb_md5_dispatch_scheduler;

  localparam int unsigned N     = 4;
  localparam logic [31:0] UMASK = 32'h0000_000F;
  localparam longint      FAR   = 64'd1_000_000_000;

  logic        clk = 1'b0;
  logic        reset, job_valid, abort;
  logic [31:0] job_base, job_count, md5_done;
  logic        job_ready, job_done, job_aborted;
  logic [31:0] md5_start, md5_reset, cand_index, busy_mask, issued;

  md5_dispatch_scheduler #(.N_UNITS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_base   (job_base),
    .job_count  (job_count),
    .abort      (abort),
    .md5_start  (md5_start),
    .md5_reset  (md5_reset),
    .md5_done   (md5_done),
    .cand_index (cand_index),
    .busy_mask  (busy_mask),
    .issued     (issued),
    .job_done   (job_done),
    .job_aborted(job_aborted)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  longint      acc_cyc = -100, end_cyc = -100, jd_cyc = -1, abort_cyc = -100, rst_cyc = -100;
  longint      bstart[N], bend[N], done_at[N];
  int unsigned mrr = 0;
  logic [31:0] job_cnt_m = '0, starts_m = '0;
  int unsigned lat_lo = 10, lat_hi = 10;
  bit          stale_mode = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, got, exp);
    end
  endtask

  // A unit may be started at cycle t only if its busy bit was already clear at t-1.
  function automatic bit is_free(input int unsigned i, input longint t);
    return (t - 1 > bend[i]);
  endfunction

  always @(negedge clk) begin : mon
    logic [31:0] eb;
    logic [31:0] e;
    int unsigned eu, au, idx;
    bit          found, got_au, anyfree;
    longint      mx;
    if (mon_en) begin
      md5_done = $urandom;
      for (int unsigned i = 0; i < N; i++) md5_done[i] = (cyc >= done_at[i]);

      if (md5_start != '0) begin
        if (exp_q.size() == 0 || cyc < acc_cyc + 2) begin
          check("unexpected_start", md5_start, 32'd0);
        end else begin
          check("start_onehot", 32'($countones(md5_start)), 32'd1);
          e = exp_q.pop_front();
          check("cand_index", cand_index, e);
          found = 1'b0;
          eu = 0;
          for (int unsigned k = 0; k < N; k++) begin
            idx = (mrr + k) % N;
            if (!found && is_free(idx, cyc)) begin
              found = 1'b1;
              eu = idx;
            end
          end
          if (!found) check("start_while_all_busy", md5_start, 32'd0);
          else        check("start_unit", md5_start, 32'd1 << eu);
          got_au = 1'b0;
          au = 0;
          for (int unsigned i = 0; i < N; i++) begin
            if (md5_start[i] && !got_au) begin
              got_au = 1'b1;
              au = i;
            end
          end
          if (got_au) begin
            bstart[au]  = cyc;
            bend[au]    = cyc + longint'($urandom_range(lat_hi, lat_lo));
            done_at[au] = bend[au];
            mrr = (au + 1) % N;
            starts_m++;
          end
        end
      end else if (exp_q.size() > 0 && cyc >= acc_cyc + 2) begin
        anyfree = 1'b0;
        for (int unsigned i = 0; i < N; i++) if (is_free(i, cyc)) anyfree = 1'b1;
        if (anyfree) check("missed_start", md5_start, 32'd1 << mrr);
      end

      eb = '0;
      for (int unsigned i = 0; i < N; i++) eb[i] = (bstart[i] <= cyc) && (cyc <= bend[i]);
      check("busy_mask", busy_mask, eb);
      check("md5_reset", md5_reset, (cyc == acc_cyc + 1 || cyc == abort_cyc + 1) ? UMASK : 32'd0);
      check("job_done", {31'd0, job_done}, {31'd0, cyc == jd_cyc});
      check("job_aborted", {31'd0, job_aborted}, {31'd0, cyc == abort_cyc + 2});
      check("job_ready", {31'd0, job_ready}, {31'd0, (cyc <= acc_cyc) || (cyc > end_cyc)});
      if (cyc == jd_cyc)        check("issued_at_done", issued, job_cnt_m);
      if (cyc == abort_cyc + 2) check("issued_at_abort", issued, starts_m);
      if (cyc == rst_cyc + 1) begin
        check("issued_after_reset", issued, 32'd0);
        check("cand_after_reset", cand_index, 32'd0);
      end

      if ((md5_reset & UMASK) != '0 && !stale_mode) begin
        for (int unsigned i = 0; i < N; i++) done_at[i] = FAR;
      end
      if (abort && cyc > acc_cyc && end_cyc == FAR) begin
        abort_cyc = cyc;
        end_cyc   = cyc + 2;
        exp_q.delete();
        for (int unsigned i = 0; i < N; i++) if (bend[i] > cyc) bend[i] = cyc;
      end
      if (reset) begin
        rst_cyc   = cyc;
        end_cyc   = cyc;
        jd_cyc    = -1;
        abort_cyc = -100;
        mrr       = 0;
        exp_q.delete();
        for (int unsigned i = 0; i < N; i++) if (bend[i] > cyc) bend[i] = cyc;
      end

      if (end_cyc == FAR && cyc > acc_cyc && exp_q.size() == 0) begin
        mx = acc_cyc + 3;
        for (int unsigned i = 0; i < N; i++) if (bend[i] + 2 > mx) mx = bend[i] + 2;
        jd_cyc  = mx;
        end_cyc = mx;
      end
    end
  end

  task automatic run_job(input logic [31:0] base, input logic [31:0] cnt);
    @(posedge clk); #1;
    job_valid = 1'b1;
    job_base  = base;
    job_count = cnt;
    acc_cyc   = cyc;
    end_cyc   = FAR;
    jd_cyc    = -1;
    job_cnt_m = cnt;
    starts_m  = '0;
    for (longint k = 0; k < longint'(cnt); k++) exp_q.push_back(base + 32'(k));
    @(posedge clk); #1;
    job_valid = 1'b0;
    job_base  = $urandom;
    job_count = $urandom;
  endtask

  task automatic wait_close(input string name);
    int unsigned n = 0;
    while (cyc <= end_cyc && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (cyc <= end_cyc) begin
      n_fail++;
      $display("FAIL %s_timeout: job still open after %0d cycles, required closed", name, n);
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < N; i++) begin
      bstart[i]  = -100;
      bend[i]    = -100;
      done_at[i] = FAR;
    end
    reset = 1'b1; job_valid = 1'b0; abort = 1'b0;
    job_base = '0; job_count = '0; md5_done = '0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    lat_lo = 10; lat_hi = 10;
    run_job(32'd100, 32'd4);
    wait_close("basic");

    lat_lo = 6; lat_hi = 9;
    run_job(32'h0000_1000, 32'd9);
    wait_close("oversub");

    lat_lo = 2; lat_hi = 7;
    stale_mode = 1'b1;
    for (int unsigned i = 0; i < N; i++) done_at[i] = 0;
    run_job(32'h00AB_0000, 32'd6);
    wait_close("stale");
    stale_mode = 1'b0;

    run_job(32'h1234_5678, 32'd0);
    wait_close("zero");

    lat_lo = 20; lat_hi = 20;
    run_job(32'd500, 32'd10);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_close("abort");
    lat_lo = 3; lat_hi = 6;
    run_job(32'd900, 32'd3);
    wait_close("after_abort");

    for (int j = 0; j < 8; j++) begin
      lat_lo = 2;
      lat_hi = $urandom_range(14, 2);
      run_job($urandom, $urandom_range(12, 0));
      wait_close("random");
    end

    lat_lo = 20; lat_hi = 20;
    run_job(32'hFFFF_FFFE, 32'd3);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
